// File: rtl/mst_wr_ctl.sv
// Master-mode write controller: round-robin channel arbitration in front of
// the 4-channel pre-fetch buffer, popping 36-bit words (BE[35:32], DATA[31:0])
// and replaying them as registered write bursts on the FT600-side bus.
module mst_wr_ctl #(
  parameter int BURST_LEN = 16,
  parameter int WIDTH     = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mst_ena,
  input  logic [3:0]       chn_ena,
  input  logic [3:0]       ch_txe_n,
  output logic             prefena,
  output logic [1:0]       prefchn,
  output logic             prefreq,
  input  logic [3:0]       prefnempt,
  input  logic [WIDTH-1:0] prefdout,
  output logic             bus_wr_n,
  output logic [1:0]       bus_chn,
  output logic [3:0]       bus_be,
  output logic [31:0]      bus_dat,
  output logic             burst_done
);

  typedef enum logic [1:0] {IDLE, FILL, BURST, GAP} state_t;

  localparam logic [7:0] BLEN = 8'(BURST_LEN);

  state_t     state;
  logic [7:0] beat_cnt;
  logic [1:0] last_chn;
  logic [3:0] elig;
  logic       sel_vld;
  logic [1:0] sel_chn;
  logic [1:0] idx;
  logic       fire;
  logic       last_beat;

  assign elig = {4{mst_ena}} & chn_ena & ~ch_txe_n;

  // Round-robin pick: scan last+4 (lowest priority) down to last+1 so the
  // nearest eligible channel after the last-served one wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_chn = last_chn;
    idx     = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = last_chn + 2'(i);
      if (elig[idx]) begin
        sel_vld = 1'b1;
        sel_chn = idx;
      end
    end
  end

  // Pop only with data present, space downstream and room left in the burst;
  // the count gate also keeps the beat counter saturating at BURST_LEN.
  assign fire      = (state == BURST) & prefnempt[prefchn] & ~ch_txe_n[prefchn]
                   & (beat_cnt < BLEN);
  assign prefreq   = fire;
  assign last_beat = (beat_cnt + 8'd1 == BLEN);

  // Controller FSM with all bus / pre-fetch outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_chn   <= 2'd3;
      prefena    <= 1'b0;
      prefchn    <= '0;
      bus_wr_n   <= 1'b1;
      bus_chn    <= '0;
      bus_be     <= '0;
      bus_dat    <= '0;
      burst_done <= 1'b0;
    end else begin
      bus_wr_n   <= 1'b1;
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            prefchn <= sel_chn;
            prefena <= 1'b1;
            state   <= FILL;
          end
        end
        FILL: begin
          if (ch_txe_n[prefchn] || !mst_ena) begin
            prefena    <= 1'b0;
            burst_done <= 1'b1;
            state      <= GAP;
          end else if (prefnempt[prefchn]) begin
            state <= BURST;
          end
        end
        BURST: begin
          if (fire) begin
            bus_wr_n <= 1'b0;
            bus_chn  <= prefchn;
            bus_be   <= prefdout[WIDTH-1 -: 4];
            bus_dat  <= prefdout[31:0];
            beat_cnt <= beat_cnt + 8'd1;
          end
          // mst_ena low still lets this cycle's beat out, then closes.
          if (ch_txe_n[prefchn] || !mst_ena || (fire && last_beat)) begin
            prefena    <= 1'b0;
            burst_done <= 1'b1;
            state      <= GAP;
          end
        end
        GAP: begin
          // prefchn stays put so an in-flight pre-fetch write lands correctly.
          beat_cnt <= '0;
          last_chn <= prefchn;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mst_wr_ctl.sv
// Directed bench for mst_wr_ctl with a behavioural 4-channel pre-fetch model
// and a negedge bus monitor that logs completed bursts.
module tb_mst_wr_ctl;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mst_ena = 1'b0;
  logic [3:0]  chn_ena = 4'h0;
  logic [3:0]  ch_txe_n = 4'hF;
  logic [3:0]  stall = 4'h0;
  logic        prefena, prefreq, bus_wr_n, burst_done;
  logic [1:0]  prefchn, bus_chn;
  logic [3:0]  prefnempt, bus_be;
  logic [31:0] bus_dat;
  logic [35:0] prefdout;

  int avail[4]  = '{default: 0};
  int popped[4] = '{default: 0};
  int total = 0;
  int bad = 0;

  // monitor state
  int inv_bad = 0, gap_bad = 0, data_bad = 0;
  int cyc = 0, cur_beats = 0, first_cyc = 0, last_cyc = 0;
  logic        prev_ena = 1'b0;
  logic [1:0]  prev_chn = 2'd0;
  logic        pend_vld = 1'b0;
  logic [37:0] pend = '0;
  int done_q[$];
  int len_q[$];
  int span_q[$];

  always #5 clk = ~clk;

  mst_wr_ctl #(.BURST_LEN(BL), .WIDTH(36)) dut (
    .clk(clk), .rst_n(rst_n), .mst_ena(mst_ena), .chn_ena(chn_ena),
    .ch_txe_n(ch_txe_n), .prefena(prefena), .prefchn(prefchn),
    .prefreq(prefreq), .prefnempt(prefnempt), .prefdout(prefdout),
    .bus_wr_n(bus_wr_n), .bus_chn(bus_chn), .bus_be(bus_be),
    .bus_dat(bus_dat), .burst_done(burst_done)
  );

  function automatic logic [35:0] word(int c, int i);
    return {4'(i + c), 32'hA000_0000 | (32'(c) << 24) | 32'(i)};
  endfunction

  // pre-fetch model: per-channel word stream, head word of prefchn on prefdout
  always_comb begin
    prefnempt = '0;
    prefdout  = word(int'(prefchn), popped[prefchn]);
    for (int c = 0; c < 4; c++)
      prefnempt[c] = (avail[c] > popped[c]) && !stall[c];
  end

  always @(posedge clk)
    if (prefreq) popped[prefchn] <= popped[prefchn] + 1;

  // bus monitor: invariants, beat data vs previous pop, per-burst log
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cur_beats = 0; pend_vld = 1'b0; prev_ena = 1'b0;
      done_q.delete(); len_q.delete(); span_q.delete();
    end else begin
      cyc++;
      if (prefreq && !prefnempt[prefchn]) inv_bad++;
      if (prev_ena && prefchn != prev_chn) gap_bad++;
      if (!bus_wr_n) begin
        if (!pend_vld || {bus_chn, bus_be, bus_dat} != pend) data_bad++;
        if (cur_beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        cur_beats++;
      end
      if (burst_done) begin
        done_q.push_back(int'(prefchn));
        len_q.push_back(cur_beats);
        span_q.push_back(cur_beats == 0 ? 0 : last_cyc - first_cyc + 1);
        cur_beats = 0;
      end
      pend_vld = prefreq;
      pend     = {prefchn, prefdout};
      prev_ena = prefena;
      prev_chn = prefchn;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mst_ena = 1'b0; chn_ena = 4'h0; ch_txe_n = 4'hF; stall = 4'h0;
    for (int c = 0; c < 4; c++) avail[c] = popped[c];
    tick(2);
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick(2);
    total++; if (prefena !== 1'b0) begin bad++; $display("FAIL reset_prefena got=%b want=0", prefena); end
    total++; if (prefchn !== 2'd0) begin bad++; $display("FAIL reset_prefchn got=%0d want=0", prefchn); end
    total++; if (prefreq !== 1'b0) begin bad++; $display("FAIL reset_prefreq got=%b want=0", prefreq); end
    total++; if (bus_wr_n !== 1'b1) begin bad++; $display("FAIL reset_bus_wr_n got=%b want=1", bus_wr_n); end
    total++; if (bus_chn !== 2'd0) begin bad++; $display("FAIL reset_bus_chn got=%0d want=0", bus_chn); end
    total++; if (bus_be !== 4'h0) begin bad++; $display("FAIL reset_bus_be got=%h want=0", bus_be); end
    total++; if (bus_dat !== 32'h0) begin bad++; $display("FAIL reset_bus_dat got=%h want=0", bus_dat); end
    total++; if (burst_done !== 1'b0) begin bad++; $display("FAIL reset_burst_done got=%b want=0", burst_done); end
    @(posedge clk); #2 rst_n = 1'b1;
    chn_ena = 4'hF; ch_txe_n = 4'h0;
    tick(3);
    total++; if (prefena !== 1'b0) begin bad++; $display("FAIL idle_disabled_prefena got=%b want=0", prefena); end
  endtask

  task automatic test_single_burst();
    int n;
    int base;
    do_reset();
    base = popped[0];
    chn_ena = 4'b0001; ch_txe_n = 4'b1110; mst_ena = 1'b1;
    n = 0; while (prefena !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (prefena !== 1'b1) begin bad++; $display("FAIL single_prefena got=%b want=1", prefena); end
    tick(2);
    avail[0] = popped[0] + 2 * BL;
    n = 0; while (done_q.size() < 2 && n < 60) begin tick(); n++; end
    total++; if (done_q.size() < 2) begin bad++; $display("FAIL single_bursts got=%0d want=2", done_q.size()); end
    if (done_q.size() >= 2) begin
      total++; if (done_q[0] != 0) begin bad++; $display("FAIL single_chn0 got=%0d want=0", done_q[0]); end
      total++; if (len_q[0] != BL) begin bad++; $display("FAIL single_len0 got=%0d want=%0d", len_q[0], BL); end
      total++; if (span_q[0] != BL) begin bad++; $display("FAIL single_span0 got=%0d want=%0d", span_q[0], BL); end
      total++; if (done_q[1] != 0) begin bad++; $display("FAIL single_chn1 got=%0d want=0", done_q[1]); end
      total++; if (len_q[1] != BL) begin bad++; $display("FAIL single_len1 got=%0d want=%0d", len_q[1], BL); end
    end
    total++; if (popped[0] - base != 2 * BL) begin bad++; $display("FAIL single_pops got=%0d want=%0d", popped[0] - base, 2 * BL); end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    chn_ena = 4'hF; ch_txe_n = 4'h0;
    for (int c = 0; c < 4; c++) avail[c] = popped[c] + 100;
    mst_ena = 1'b1;
    n = 0; while (done_q.size() < 5 && n < 100) begin tick(); n++; end
    total++; if (done_q.size() < 5) begin bad++; $display("FAIL rr_bursts got=%0d want=5", done_q.size()); end
    if (done_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        total++; if (done_q[i] != i % 4) begin bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, done_q[i], i % 4); end
        total++; if (len_q[i] != BL) begin bad++; $display("FAIL rr_len[%0d] got=%0d want=%0d", i, len_q[i], BL); end
      end
    end
  endtask

  task automatic test_back_pressure();
    int n;
    int beats;
    do_reset();
    chn_ena = 4'b0110; ch_txe_n = 4'h0;
    avail[1] = popped[1] + 10; avail[2] = popped[2] + 10;
    mst_ena = 1'b1;
    beats = 0; n = 0;
    while (beats < 2 && n < 40) begin tick(); if (bus_wr_n === 1'b0) beats++; n++; end
    total++; if (beats != 2) begin bad++; $display("FAIL bp_beats got=%0d want=2", beats); end
    ch_txe_n[1] = 1'b1;
    #1;
    total++; if (prefreq !== 1'b0) begin bad++; $display("FAIL bp_prefreq got=%b want=0", prefreq); end
    tick();
    total++; if (burst_done !== 1'b1) begin bad++; $display("FAIL bp_burst_done got=%b want=1", burst_done); end
    n = 0; while (done_q.size() < 2 && n < 60) begin tick(); n++; end
    total++; if (done_q.size() < 2) begin bad++; $display("FAIL bp_bursts got=%0d want=2", done_q.size()); end
    if (done_q.size() >= 2) begin
      total++; if (done_q[0] != 1) begin bad++; $display("FAIL bp_chn0 got=%0d want=1", done_q[0]); end
      total++; if (len_q[0] != 2) begin bad++; $display("FAIL bp_len0 got=%0d want=2", len_q[0]); end
      total++; if (done_q[1] != 2) begin bad++; $display("FAIL bp_next_chn got=%0d want=2", done_q[1]); end
      total++; if (len_q[1] != BL) begin bad++; $display("FAIL bp_len1 got=%0d want=%0d", len_q[1], BL); end
    end
    total++; if (avail[1] - popped[1] != 8) begin bad++; $display("FAIL bp_fifo_left got=%0d want=8", avail[1] - popped[1]); end
  endtask

  task automatic test_empty_stall();
    int n;
    int beats;
    do_reset();
    chn_ena = 4'b0001; ch_txe_n = 4'b1110;
    avail[0] = popped[0] + 2 * BL;
    mst_ena = 1'b1;
    beats = 0; n = 0;
    while (beats < 2 && n < 40) begin tick(); if (bus_wr_n === 1'b0) beats++; n++; end
    total++; if (beats != 2) begin bad++; $display("FAIL stall_beats got=%0d want=2", beats); end
    stall[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (bus_wr_n !== 1'b1) begin bad++; $display("FAIL stall_wr_n[%0d] got=%b want=1", k, bus_wr_n); end
    end
    stall[0] = 1'b0;
    n = 0; while (done_q.size() < 1 && n < 40) begin tick(); n++; end
    total++; if (done_q.size() < 1) begin bad++; $display("FAIL stall_bursts got=%0d want=1", done_q.size()); end
    if (done_q.size() >= 1) begin
      total++; if (len_q[0] != BL) begin bad++; $display("FAIL stall_len got=%0d want=%0d", len_q[0], BL); end
      total++; if (span_q[0] != BL + 3) begin bad++; $display("FAIL stall_span got=%0d want=%0d", span_q[0], BL + 3); end
    end
  endtask

  task automatic test_gap_hold();
    int n;
    logic [1:0] held;
    do_reset();
    chn_ena = 4'b0100; ch_txe_n = 4'b1011;
    avail[2] = popped[2] + BL;
    mst_ena = 1'b1;
    n = 0; while (prefena !== 1'b1 && n < 20) begin tick(); n++; end
    held = prefchn;
    n = 0; while (prefena === 1'b1 && n < 30) begin held = prefchn; tick(); n++; end
    total++; if (prefena !== 1'b0) begin bad++; $display("FAIL gap_prefena got=%b want=0", prefena); end
    total++; if (prefchn !== 2'd2) begin bad++; $display("FAIL gap_prefchn got=%0d want=2", prefchn); end
    total++; if (prefchn !== held) begin bad++; $display("FAIL gap_hold got=%0d want=%0d", prefchn, held); end
    total++; if (burst_done !== 1'b1) begin bad++; $display("FAIL gap_done got=%b want=1", burst_done); end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    int beats;
    do_reset();
    chn_ena = 4'b0100; ch_txe_n = 4'h0;
    avail[0] = popped[0] + 20; avail[2] = popped[2] + 20;
    mst_ena = 1'b1;
    beats = 0; n = 0;
    while (beats < 2 && n < 40) begin tick(); if (bus_wr_n === 1'b0) beats++; n++; end
    total++; if (beats != 2) begin bad++; $display("FAIL rst_beats got=%0d want=2", beats); end
    rst_n = 1'b0;
    #1;
    total++; if (bus_wr_n !== 1'b1) begin bad++; $display("FAIL rst_bus_wr_n got=%b want=1", bus_wr_n); end
    total++; if (prefena !== 1'b0) begin bad++; $display("FAIL rst_prefena got=%b want=0", prefena); end
    total++; if (prefreq !== 1'b0) begin bad++; $display("FAIL rst_prefreq got=%b want=0", prefreq); end
    chn_ena = 4'hF;
    tick(2);
    @(posedge clk); #2 rst_n = 1'b1;
    n = 0; while (done_q.size() < 1 && n < 40) begin tick(); n++; end
    total++; if (done_q.size() < 1) begin bad++; $display("FAIL rst_bursts got=%0d want=1", done_q.size()); end
    if (done_q.size() >= 1) begin
      total++; if (done_q[0] != 0) begin bad++; $display("FAIL rst_first_chn got=%0d want=0", done_q[0]); end
      total++; if (len_q[0] != BL) begin bad++; $display("FAIL rst_len got=%0d want=%0d", len_q[0], BL); end
    end
  endtask

  task automatic test_invariants();
    total++; if (inv_bad != 0) begin bad++; $display("FAIL inv_prefreq_empty got=%0d want=0", inv_bad); end
    total++; if (gap_bad != 0) begin bad++; $display("FAIL inv_prefchn_hold got=%0d want=0", gap_bad); end
    total++; if (data_bad != 0) begin bad++; $display("FAIL inv_beat_data got=%0d want=0", data_bad); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_back_pressure();
    test_empty_stall();
    test_gap_hold();
    test_reset_mid_burst();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mst_wr_ctl.md
Name: mst_wr_ctl

Overview:
- Master-mode write controller downstream of the 4-channel pre-fetch buffer.
- Arbitrates the four streaming channels round-robin and steers the pre-fetch stage via prefena, prefchn and prefreq.
- Pops 36-bit pre-fetch words, where bits [35:32] are byte enables and bits [31:0] are data, and drives them as registered write bursts onto the FT600-side bus.
- Flow control is per channel, using the active-low space-available flags ch_txe_n.

Parameters:
- BURST_LEN, 16: maximum beats per channel burst (1..255).
- WIDTH, 36: pre-fetch word width (4 byte-enable bits plus 32 data bits).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mst_ena  in  1  global enable. Low means no new burst is started.
- chn_ena  in  4  per-channel enable mask.
- ch_txe_n  in  4  per-channel FT600 space flag. Low means the channel can accept data.
- prefena  out  1  pre-fetch enable.
- prefchn  out  2  selected pre-fetch channel.
- prefreq  out  1  pre-fetch pop strobe.
- prefnempt  in  4  pre-fetch per-channel not-empty.
- prefdout  in  WIDTH  pre-fetch head word of channel prefchn (combinational).
- bus_wr_n  out  1  write strobe, active low.
- bus_chn  out  2  channel of the current beat.
- bus_be  out  4  byte enables of the current beat.
- bus_dat  out  32  data of the current beat.
- burst_done  out  1  one-cycle pulse when a burst ends.

Behaviour:
- Reset values: prefena=0, prefchn=0, prefreq=0, bus_wr_n=1, bus_chn=0, bus_be=0, bus_dat=0, burst_done=0. State is IDLE, beat counter is 0, and the round-robin pointer (last-served channel) is 3.
- Eligibility: channel n is eligible when mst_ena & chn_ena[n] & !ch_txe_n[n].
- IDLE:
  - If any channel is eligible, select the first eligible channel searching upward from last+1 (mod 4).
  - Register the selection into prefchn and go to FILL.
  - Otherwise stay in IDLE with prefena=0.
- FILL:
  - prefena=1, prefchn held.
  - Go to BURST when prefnempt[prefchn]=1.
  - If ch_txe_n[prefchn] goes high or mst_ena goes low first, go to GAP.
- BURST:
  - prefena=1, prefchn held.
  - fire = prefnempt[prefchn] & !ch_txe_n[prefchn] & (beat count < BURST_LEN).
  - prefreq = fire (combinational).
  - On fire, register bus_dat=prefdout[31:0], bus_be=prefdout[35:32], bus_chn=prefchn, bus_wr_n=0, and increment the beat count. Latency is one cycle from pop to bus beat.
  - With no fire, bus_wr_n=1 on the next cycle. An empty pre-fetch FIFO stalls the burst and does not end it.
  - The burst ends, going to GAP, when either of these holds:
    - the beat count reaches BURST_LEN after a fire;
    - ch_txe_n[prefchn]=1, in which case the current cycle does not fire.
  - mst_ena low ends the burst after the current beat.
- GAP (exactly 1 cycle):
  - prefena=0, prefreq=0, prefchn still held, so the pre-fetch write in flight lands in the correct channel.
  - burst_done=1 in this cycle. The beat count clears, the pointer updates to prefchn, and the state returns to IDLE.
- Invariant: prefchn never changes in the cycle after prefena was 1.
- Invariant: prefreq is never asserted when prefnempt[prefchn]=0.
- Words left in a channel's pre-fetch FIFO after a burst stay there and are sent first in that channel's next burst.
- A single eligible channel is re-selected every burst. With all four eligible, the order is strictly 0, 1, 2, 3, 0, ...
- The beat counter is 8 bits, saturates at BURST_LEN and never wraps.
- Asynchronous reset mid-burst forces all outputs to their reset values immediately. Any partial beat is discarded.

Test Plan:
- Single-channel burst:
  - Stimulus: BURST_LEN=4, chn_ena=0001, ch_txe_n=1110, prefnempt[0] goes high 2 cycles after prefena.
  - Required: 4 consecutive bus_wr_n=0 beats on bus_chn=0, each with bus_dat equal to the prefdout popped in the preceding cycle; burst_done pulses once; then a new burst starts on channel 0.
- Round-robin:
  - Stimulus: all channels enabled, all ch_txe_n=0, all prefnempt=1.
  - Required: bursts are served in channel order 0, 1, 2, 3, 0, and each burst is exactly BURST_LEN beats.
- Back-pressure:
  - Stimulus: ch_txe_n[1] rises after beat 2 of a channel-1 burst.
  - Required: no further prefreq; burst_done is asserted; channel 2 is selected next; the pre-fetch FIFO still holds the remaining words.
- Empty stall:
  - Stimulus: prefnempt[prefchn] drops for 3 cycles mid-burst.
  - Required: bus_wr_n=1 for those 3 cycles, the burst resumes, and the total beat count is still BURST_LEN.
- GAP hold:
  - Check: in the cycle after prefena falls, prefchn is unchanged.
  - Check: prefreq is never asserted while prefnempt[prefchn]=0 (checked every cycle).
- Reset mid-burst:
  - Stimulus: rst_n low at beat 2.
  - Required: bus_wr_n=1, prefena=0, prefreq=0 immediately; after release, the first burst goes to channel 0.
